// File: rtl/game_pkg.sv
// game_pkg
//   Shared types and default tuning constants for the jumper game slice.
//   phys_state_t : player physics state, also exported on the jumper_physics
//                  state port.
//   DEF_*        : default parameter values for jumper_physics (pixels,
//                  pixels/frame, frames).
package game_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        SCROLL = 2'd1,
        DROP   = 2'd2,
        OVER   = 2'd3
    } phys_state_t;

    localparam int DEF_POS_W       = 10;
    localparam int DEF_VEL_W       = 8;
    localparam int DEF_X_MIN       = 170;
    localparam int DEF_X_MAX       = 469;
    localparam int DEF_Y_MAX       = 479;
    localparam int DEF_X_START     = 320;
    localparam int DEF_Y_START     = 390;
    localparam int DEF_HALF        = 17;
    localparam int DEF_SCROLL_LINE = 239;
    localparam int DEF_JUMP_V      = 8;
    localparam int DEF_BOOST_V     = 15;
    localparam int DEF_X_SPEED     = 2;
    localparam int DEF_GRAV_DIV    = 4;
    localparam int DEF_MAX_FALL    = 12;

endpackage

// File: rtl/x_wrap.sv
// x_wrap
//   Combinational horizontal step with wrap-around. A sprite that has fully
//   left the playfield on one side re-enters from the other side.
//   Ports:
//     pos_x  in  POS_W  current sprite centre x
//     dx     in  POS_W  horizontal step, two's complement
//     next_x out POS_W  x for the next frame
module x_wrap #(
    parameter int POS_W = 10,
    parameter int X_MIN = 170,
    parameter int X_MAX = 469,
    parameter int HALF  = 17
) (
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] dx,
    output logic [POS_W-1:0] next_x
);

    localparam logic [POS_W-1:0] RIGHT_EDGE = POS_W'(X_MAX + HALF);
    localparam logic [POS_W-1:0] LEFT_EDGE  = POS_W'(X_MIN - HALF);

    // dx is two's complement, so modular addition yields the signed step.
    always_comb begin
        if (pos_x >= RIGHT_EDGE) begin
            next_x = LEFT_EDGE + dx;
        end else if (pos_x <= LEFT_EDGE) begin
            next_x = RIGHT_EDGE + dx;
        end else begin
            next_x = pos_x + dx;
        end
    end

endmodule

// File: rtl/jumper_physics.sv
// jumper_physics
//   Per-frame physics for the jumping sprite: gravity, platform bounce,
//   boost, horizontal movement with wrap, world scrolling and fall-out.
//   All state advances only on frame_tick.
//   Ports:
//     Clk, Reset_n            clock, asynchronous active-low reset
//     frame_tick              one-Clk pulse per video frame
//     move_left, move_right   key levels
//     collision, boost        platform / spring contact this frame
//     restart                 leave OVER at the next tick
//     pos_x, pos_y            sprite centre
//     vel_y                   signed vertical velocity (+ is downward)
//     scroll_amt/scroll_valid world scroll this frame, one-Clk qualifier
//     state, dropped          physics state; high in DROP and OVER
module jumper_physics
    import game_pkg::*;
#(
    parameter int POS_W       = DEF_POS_W,
    parameter int VEL_W       = DEF_VEL_W,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int X_START     = DEF_X_START,
    parameter int Y_START     = DEF_Y_START,
    parameter int HALF        = DEF_HALF,
    parameter int SCROLL_LINE = DEF_SCROLL_LINE,
    parameter int JUMP_V      = DEF_JUMP_V,
    parameter int BOOST_V     = DEF_BOOST_V,
    parameter int X_SPEED     = DEF_X_SPEED,
    parameter int GRAV_DIV    = DEF_GRAV_DIV,
    parameter int MAX_FALL    = DEF_MAX_FALL
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_tick,
    input  logic                    move_left,
    input  logic                    move_right,
    input  logic                    collision,
    input  logic                    boost,
    input  logic                    restart,
    output logic [POS_W-1:0]        pos_x,
    output logic [POS_W-1:0]        pos_y,
    output logic signed [VEL_W-1:0] vel_y,
    output logic [POS_W-1:0]        scroll_amt,
    output logic                    scroll_valid,
    output phys_state_t             state,
    output logic                    dropped
);

    localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic [POS_W-1:0] SPAWN_X  = POS_W'(X_START);
    localparam logic [POS_W-1:0] SPAWN_Y  = POS_W'(Y_START);
    // pos_y + HALF >= Y_MAX rewritten so the sum cannot overflow POS_W.
    localparam logic [POS_W-1:0] FLOOR_Y  = POS_W'(Y_MAX - HALF);
    localparam logic [POS_W-1:0] SCROLL_Y = POS_W'(SCROLL_LINE);
    localparam logic [POS_W-1:0] OVER_Y   = POS_W'(Y_MAX + 2 * HALF);
    localparam logic [POS_W-1:0] DX_LEFT  = POS_W'(-X_SPEED);
    localparam logic [POS_W-1:0] DX_RIGHT = POS_W'(X_SPEED);

    localparam logic signed [VEL_W-1:0] V_JUMP  = VEL_W'(-JUMP_V);
    localparam logic signed [VEL_W-1:0] V_BOOST = VEL_W'(-BOOST_V);
    localparam logic signed [VEL_W-1:0] V_DROP  = VEL_W'(2);
    localparam logic signed [VEL_W-1:0] V_MAX   = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W-1:0] V_ONE   = VEL_W'(1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAV_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]        grav_cnt, grav_cnt_nxt;
    logic [POS_W-1:0]        pos_x_nxt, pos_y_nxt, scroll_amt_nxt;
    logic signed [VEL_W-1:0] vel_y_nxt;
    logic                    scroll_valid_nxt;
    phys_state_t             state_nxt;

    logic [POS_W-1:0] vel_ext;
    logic [POS_W-1:0] dx;
    logic [POS_W-1:0] wrap_x;
    logic             vel_neg;
    logic             vel_pos;

    // Size cast of a signed operand sign-extends.
    assign vel_ext = POS_W'(vel_y);
    assign vel_neg = vel_y[VEL_W-1];
    assign vel_pos = !vel_y[VEL_W-1] && (vel_y != '0);

    assign dx = (move_left && !move_right) ? DX_LEFT  :
                (move_right && !move_left) ? DX_RIGHT : '0;

    x_wrap #(
        .POS_W (POS_W),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .HALF  (HALF)
    ) u_x_wrap (
        .pos_x  (pos_x),
        .dx     (dx),
        .next_x (wrap_x)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x        <= SPAWN_X;
            pos_y        <= SPAWN_Y;
            vel_y        <= V_JUMP;
            grav_cnt     <= '0;
            scroll_amt   <= '0;
            scroll_valid <= 1'b0;
            state        <= PLAY;
        end else begin
            pos_x        <= pos_x_nxt;
            pos_y        <= pos_y_nxt;
            vel_y        <= vel_y_nxt;
            grav_cnt     <= grav_cnt_nxt;
            scroll_amt   <= scroll_amt_nxt;
            scroll_valid <= scroll_valid_nxt;
            state        <= state_nxt;
        end
    end

    // Motion and state decisions all read the pre-tick registers, so a
    // velocity change shows up in position one tick later.
    always_comb begin
        pos_x_nxt        = pos_x;
        pos_y_nxt        = pos_y;
        vel_y_nxt        = vel_y;
        grav_cnt_nxt     = grav_cnt;
        scroll_amt_nxt   = scroll_amt;
        scroll_valid_nxt = 1'b0;
        state_nxt        = state;

        if (frame_tick) begin
            unique case (state)
                PLAY, SCROLL: begin
                    pos_x_nxt      = wrap_x;
                    scroll_amt_nxt = '0;

                    // While scrolling upward the world moves instead of the sprite.
                    if (state == SCROLL && vel_neg) begin
                        scroll_amt_nxt   = -vel_ext;
                        scroll_valid_nxt = 1'b1;
                    end else begin
                        pos_y_nxt = pos_y + vel_ext;
                    end

                    if (state == PLAY && pos_y <= SCROLL_Y && vel_neg) begin
                        state_nxt = SCROLL;
                    end else if (state == SCROLL && !vel_neg) begin
                        state_nxt = PLAY;
                    end

                    // Floor hit overrides any scroll transition chosen above.
                    if (boost) begin
                        vel_y_nxt    = V_BOOST;
                        grav_cnt_nxt = '0;
                    end else if (pos_y >= FLOOR_Y) begin
                        vel_y_nxt = V_DROP;
                        state_nxt = DROP;
                    end else if (collision && vel_pos) begin
                        vel_y_nxt    = V_JUMP;
                        grav_cnt_nxt = '0;
                    end else if (grav_cnt == CNT_LAST) begin
                        grav_cnt_nxt = '0;
                        vel_y_nxt    = (vel_y >= V_MAX) ? V_MAX : vel_y + V_ONE;
                    end else begin
                        grav_cnt_nxt = grav_cnt + CNT_ONE;
                    end
                end

                DROP: begin
                    pos_x_nxt = wrap_x;
                    pos_y_nxt = pos_y + vel_ext;
                    if (pos_y_nxt >= OVER_Y) begin
                        state_nxt = OVER;
                    end
                end

                OVER: begin
                    if (restart) begin
                        pos_x_nxt      = SPAWN_X;
                        pos_y_nxt      = SPAWN_Y;
                        vel_y_nxt      = V_JUMP;
                        grav_cnt_nxt   = '0;
                        scroll_amt_nxt = '0;
                        state_nxt      = PLAY;
                    end
                end
            endcase
        end
    end

    assign dropped = (state == DROP) || (state == OVER);

endmodule

// File: tb/tb_jumper_physics.sv
// tb_jumper_physics
//   Scoreboard bench for jumper_physics. The driver issues frame ticks and
//   advances a frame-level reference model, queueing the expected post-tick
//   values and expected scroll pulses; independent monitors pop and compare
//   when the DUT updates or raises scroll_valid.
module tb_jumper_physics;
    import game_pkg::*;

    localparam int POS_W    = 10;
    localparam int VEL_W    = 8;
    localparam int X_MIN    = 170;
    localparam int X_MAX    = 469;
    localparam int Y_MAX    = 479;
    localparam int X_START  = 320;
    localparam int Y_START  = 390;
    localparam int HALF     = 17;
    localparam int SCR_LINE = 239;
    localparam int JUMP_V   = 8;
    localparam int BOOST_V  = 15;
    localparam int X_SPEED  = 2;
    localparam int GRAV_DIV = 4;
    localparam int MAX_FALL = 12;

    logic Clk = 1'b0;
    logic Reset_n, frame_tick, move_left, move_right, collision, boost, restart;
    logic [POS_W-1:0]        pos_x, pos_y, scroll_amt;
    logic signed [VEL_W-1:0] vel_y;
    logic                    scroll_valid, dropped;
    phys_state_t             state;

    jumper_physics #(
        .POS_W       (POS_W),
        .VEL_W       (VEL_W),
        .X_MIN       (X_MIN),
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .X_START     (X_START),
        .Y_START     (Y_START),
        .HALF        (HALF),
        .SCROLL_LINE (SCR_LINE),
        .JUMP_V      (JUMP_V),
        .BOOST_V     (BOOST_V),
        .X_SPEED     (X_SPEED),
        .GRAV_DIV    (GRAV_DIV),
        .MAX_FALL    (MAX_FALL)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .move_left    (move_left),
        .move_right   (move_right),
        .collision    (collision),
        .boost        (boost),
        .restart      (restart),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .vel_y        (vel_y),
        .scroll_amt   (scroll_amt),
        .scroll_valid (scroll_valid),
        .state        (state),
        .dropped      (dropped)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          x;
        int          y;
        int          v;
        phys_state_t st;
    } exp_t;

    exp_t exp_q[$];
    int   scroll_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one frame per call, plain integer arithmetic.
    int          m_x, m_y, m_v, m_ticks_since_grav;
    phys_state_t m_st;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wrap_x(input int x, input int dx);
        if (x >= X_MAX + HALF)      return X_MIN - HALF + dx;
        else if (x <= X_MIN - HALF) return X_MAX + HALF + dx;
        else                        return x + dx;
    endfunction

    task automatic model_spawn();
        m_x = X_START;
        m_y = Y_START;
        m_v = -JUMP_V;
        m_ticks_since_grav = 0;
        m_st = PLAY;
    endtask

    task automatic model_reset();
        model_spawn();
        exp_q.delete();
        scroll_q.delete();
    endtask

    task automatic model_step(input bit l, input bit r, input bit c, input bit b, input bit rs);
        int          dx;
        int          old_v;
        int          old_y;
        phys_state_t ns;
        exp_t        e;
        dx    = (l && !r) ? -X_SPEED : ((r && !l) ? X_SPEED : 0);
        old_v = m_v;
        old_y = m_y;
        ns    = m_st;
        case (m_st)
            PLAY, SCROLL: begin
                m_x = wrap_x(m_x, dx);
                if (m_st == SCROLL && old_v < 0) scroll_q.push_back(-old_v);
                else m_y = (old_y + old_v) & ((1 << POS_W) - 1);
                if (m_st == PLAY && old_y <= SCR_LINE && old_v < 0) ns = SCROLL;
                else if (m_st == SCROLL && old_v >= 0) ns = PLAY;
                if (b) begin
                    m_v = -BOOST_V;
                    m_ticks_since_grav = 0;
                end else if (old_y + HALF >= Y_MAX) begin
                    m_v = 2;
                    ns  = DROP;
                end else if (c && old_v > 0) begin
                    m_v = -JUMP_V;
                    m_ticks_since_grav = 0;
                end else begin
                    m_ticks_since_grav++;
                    if (m_ticks_since_grav == GRAV_DIV) begin
                        m_ticks_since_grav = 0;
                        if (m_v < MAX_FALL) m_v++;
                    end
                end
            end
            DROP: begin
                m_x = wrap_x(m_x, dx);
                m_y = (old_y + old_v) & ((1 << POS_W) - 1);
                if (m_y >= Y_MAX + 2 * HALF) ns = OVER;
            end
            OVER: begin
                if (rs) begin
                    model_spawn();
                    ns = PLAY;
                end
            end
        endcase
        m_st = ns;
        e.x  = m_x;
        e.y  = m_y;
        e.v  = m_v;
        e.st = m_st;
        exp_q.push_back(e);
    endtask

    // Monitor: DUT registers update on a tick edge; compare just after it.
    always @(posedge Clk) begin
        if (frame_tick && Reset_n) begin
            exp_t e;
            #1;
            if (exp_q.size() == 0) begin
                check("tick_expectation_present", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("pos_x", int'(pos_x), e.x);
                check("pos_y", int'(pos_y), e.y);
                check("vel_y", int'(vel_y), e.v);
                check("state", int'(state), int'(e.st));
                check("dropped", int'(dropped), int'(e.st == DROP || e.st == OVER));
            end
        end
    end

    // Monitor: every Clk that scroll_valid is high consumes one expected pulse.
    always @(negedge Clk) begin
        if (Reset_n && scroll_valid) begin
            if (scroll_q.size() == 0) begin
                check("scroll_pulse_expected", 1, 0);
            end else begin
                check("scroll_amt", int'(scroll_amt), scroll_q.pop_front());
            end
        end
    end

    task automatic tick(input bit l, input bit r, input bit c, input bit b, input bit rs);
        int idle;
        idle = $urandom_range(0, 2);
        // Inputs toggling between ticks must have no effect.
        for (int i = 0; i < idle; i++) begin
            @(negedge Clk);
            move_left  = 1'($urandom_range(0, 1));
            move_right = 1'($urandom_range(0, 1));
            collision  = 1'($urandom_range(0, 1));
            boost      = 1'($urandom_range(0, 1));
            restart    = 1'($urandom_range(0, 1));
        end
        @(negedge Clk);
        move_left  = l;
        move_right = r;
        collision  = c;
        boost      = b;
        restart    = rs;
        frame_tick = 1'b1;
        model_step(l, r, c, b, rs);
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic check_spawn_values(input string tag);
        check({tag, "_pos_x"}, int'(pos_x), X_START);
        check({tag, "_pos_y"}, int'(pos_y), Y_START);
        check({tag, "_vel_y"}, int'(vel_y), -JUMP_V);
        check({tag, "_scroll_amt"}, int'(scroll_amt), 0);
        check({tag, "_scroll_valid"}, int'(scroll_valid), 0);
        check({tag, "_dropped"}, int'(dropped), 0);
        check({tag, "_state"}, int'(state), int'(PLAY));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_spawn_values("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        collision  = 1'b0;
        boost      = 1'b0;
        restart    = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        do_reset();

        // Rise from spawn: one-tick latency and gravity every fourth tick.
        tick(0, 0, 0, 0, 0);
        check("rise_t1_pos_y", int'(pos_y), 382);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("rise_t3_pos_y", int'(pos_y), 366);
        check("rise_t3_vel_y", int'(vel_y), -8);
        tick(0, 0, 0, 0, 0);
        check("rise_t4_vel_y", int'(vel_y), -7);

        // Platform under the sprite every frame: bounces only when falling,
        // while held keys walk the sprite across both wrap edges.
        for (int i = 0; i < 150; i++) tick(1, 0, 1, 0, 0);
        for (int i = 0; i < 200; i++) tick(0, 1, 1, 0, 0);

        // Free fall to the floor, through DROP to OVER, then restart.
        do_reset();
        for (int i = 0; i < 300 && m_st != OVER; i++) tick(i[3], 0, 0, 0, 0);
        check("fall_state_over", int'(state), int'(OVER));
        check("fall_dropped", int'(dropped), 1);
        for (int i = 0; i < 3; i++) tick(1, 0, 1, 1, 0);
        tick(0, 1, 0, 0, 1);
        check("restart_pos_x", int'(pos_x), X_START);
        check("restart_pos_y", int'(pos_y), Y_START);
        check("restart_state", int'(state), int'(PLAY));

        // Boost together with collision climbs into SCROLL; reset mid-scroll.
        do_reset();
        for (int i = 0; i < 60 && m_st != SCROLL; i++) tick(0, 0, 1, 1, 0);
        check("boost_state_scroll", int'(state), int'(SCROLL));
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 1, 0);
        @(negedge Clk);
        move_left  = 1'b0;
        move_right = 1'b0;
        collision  = 1'b0;
        boost      = 1'b1;
        restart    = 1'b0;
        frame_tick = 1'b1;
        model_step(0, 0, 0, 1, 0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_spawn_values("scroll_reset");
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;

        // Randomised play, with one asynchronous reset midway.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge Clk);
        check("tick_queue_drained", exp_q.size(), 0);
        check("scroll_queue_drained", scroll_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
